// File: rtl/rr_chan_mux_pkg.sv
// Shared definitions for the round-robin channel mux.
//   - DEFAULT_WIDTH / DEFAULT_NCH : default data width and channel count
//   - clog2_min1()                : index width helper, never returns less than 1
//   - rr_state_t                  : arbiter lock state. Only used when RR_CHAN_MUX_LOCK_EN is defined.
package rr_chan_mux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NCH   = 4;

  typedef enum logic {UNLOCKED, LOCKED} rr_state_t;

  // ceil(log2(n)), clamped to 1 so that a 2-channel (or degenerate) mux still
  // gets a usable 1-bit index.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_chan_mux_arbiter.sv
// rr_arbiter: round-robin grant generator for rr_chan_mux.
// Holds the rotating priority pointer and, when RR_CHAN_MUX_LOCK_EN is defined,
// the packet lock state.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-channel request (in_valid)
//   advance      a beat is being accepted from the granted channel this cycle
//   last         the accepted beat ends its packet (tied high without packet lock)
//   grant        granted channel index
//   grant_valid  grant points at a requesting channel
module rr_arbiter
  import rr_chan_mux_pkg::*;
#(
  parameter int NCH  = DEFAULT_NCH,
  parameter int SELW = clog2_min1(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  input  logic            last,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW-1:0] rr_grant;
  logic            rr_valid;

  // Increment modulo NCH. This is written out explicitly so the pointer can never
  // leave 0..NCH-1 when NCH is not a power of two.
  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
    if (int'(idx) >= NCH - 1) return '0;
    return idx + SELW'(1);
  endfunction

  // The scan runs from the farthest offset back to ptr. The lowest offset from
  // ptr is therefore written last and wins.
  always_comb begin
    int              idx;
    logic [SELW-1:0] idx_sel;
    rr_grant = '0;
    rr_valid = 1'b0;
    idx      = 0;
    idx_sel  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      idx_sel = SELW'(idx);
      if (req[idx_sel]) begin
        rr_grant = idx_sel;
        rr_valid = 1'b1;
      end
    end
  end

`ifdef RR_CHAN_MUX_LOCK_EN
  rr_state_t       state;
  rr_state_t       state_nxt;
  logic [SELW-1:0] lock_chan;
  logic [SELW-1:0] lock_chan_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      lock_chan <= '0;
    end else begin
      state     <= state_nxt;
      lock_chan <= lock_chan_nxt;
    end
  end

  // While locked, the grant is pinned to the packet owner. If the owner drops
  // valid, grant_valid falls and the whole mux bubbles.
  always_comb begin
    state_nxt     = state;
    lock_chan_nxt = lock_chan;
    grant         = rr_grant;
    grant_valid   = rr_valid;
    ptr_nxt       = ptr;
    case (state)
      UNLOCKED: begin
        if (advance) begin
          if (last) begin
            ptr_nxt = wrap_inc(rr_grant);
          end else begin
            state_nxt     = LOCKED;
            lock_chan_nxt = rr_grant;
          end
        end
      end
      LOCKED: begin
        grant       = lock_chan;
        grant_valid = req[lock_chan];
        if (advance && last) begin
          state_nxt = UNLOCKED;
          ptr_nxt   = wrap_inc(lock_chan);
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end
`else
  always_comb begin
    grant       = rr_grant;
    grant_valid = rr_valid;
    ptr_nxt     = ptr;
    if (advance && last) ptr_nxt = wrap_inc(rr_grant);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/rr_chan_mux.sv
// rr_chan_mux: round-robin mux of NCH valid/ready source channels onto a single
// registered valid/ready output. The downstream ready is steered back to the
// granted source only.
// Optional feature macro: RR_CHAN_MUX_LOCK_EN (packet lock). When it is defined,
// the ports in_last and out_last are added.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    per-channel valid
//   in_data     channel i occupies bits [i*WIDTH +: WIDTH]
//   in_last     per-channel end-of-packet (lock build only)
//   in_ready    per-channel ready, one-hot or zero
//   out_valid   output register holds a beat
//   out_data    registered data
//   out_chan    source channel of out_data
//   out_last    registered end-of-packet (lock build only)
//   out_ready   downstream accepts the beat
module rr_chan_mux
  import rr_chan_mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NCH   = DEFAULT_NCH,
  localparam int SELW  = clog2_min1(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
`ifdef RR_CHAN_MUX_LOCK_EN
  input  logic [NCH-1:0]     in_last,
  output logic               out_last,
`endif
  output logic [NCH-1:0]     in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             grant_last;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] chan_data [NCH];
  logic [WIDTH-1:0] sel_data_p0;

  // Gating with rst_n holds in_ready low while reset is asserted. Without it, the
  // empty output register would advertise space during reset.
  assign can_accept = rst_n & (~out_valid | out_ready);
  assign accept     = can_accept & grant_valid;

`ifdef RR_CHAN_MUX_LOCK_EN
  assign grant_last = in_last[grant];
`else
  assign grant_last = 1'b1;
`endif

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (accept),
    .last        (grant_last),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    for (int i = 0; i < NCH; i++) chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign sel_data_p0 = chan_data[grant];

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // ---- stage p0 -> output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
`ifdef RR_CHAN_MUX_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_p0;
      out_chan  <= grant;
`ifdef RR_CHAN_MUX_LOCK_EN
      out_last  <= grant_last;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_chan_mux.md
Name: rr_chan_mux

Overview:
- Parametrised successor to the gate-level mux/demux cells.
- Selects one of NCH valid/ready source channels onto a single registered output channel using round-robin arbitration.
- Demuxes the downstream ready back to the granted source only.
- Sits between multiple bus masters (fetch, load/store, DMA) and a shared bus port of the uPx core.

Parameters:
- WIDTH, 8: data width per channel in bits.
- NCH, 4: number of input channels, range 2..16.
- SELW, $clog2(NCH): width of channel index. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NCH  per-channel valid.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel ready, at most one bit set.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  index of the source of out_data.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0. in_ready is combinational, so it is 0 while rst_n=0.
- Transfer rules:
  - Input transfer on channel i when in_valid[i] & in_ready[i].
  - Output transfer when out_valid & out_ready.
- can_accept = !out_valid | out_ready. Full throughput: 1 beat/cycle when out_ready is held high.
- Grant (combinational):
  - grant is the first i with in_valid[i]=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (modulo NCH).
  - No valid input means no grant.
  - in_ready[i] = can_accept & (grant==i). in_ready never depends on in_valid of the same channel other than through grant.
- Input accept (edge): out_data <= in_data[grant], out_chan <= grant, out_valid <= 1, ptr <= (grant+1) mod NCH. Wrap: grant=NCH-1 gives ptr=0.
- Output drain with no input accept in the same cycle: out_valid <= 0; out_data and out_chan hold their values.
- Simultaneous drain and accept: the register is reloaded and out_valid stays 1.
- Stall (out_valid & !out_ready): out_valid, out_data and out_chan stay stable; all in_ready=0; ptr does not move.
- Latency: input transfer at edge N appears on out_* after edge N.
- ptr changes only on an input transfer.
- Reset mid-operation discards the held beat; there is no recovery.
- NCH not a power of two: pointer arithmetic is explicit modulo NCH; ptr never holds a value >= NCH.

Optional Feature:
- Macro RR_CHAN_MUX_LOCK_EN enables packet lock.
- Enabled:
  - Adds ports in_last (input, NCH) and out_last (output, 1, registered with the data, reset 0).
  - After accepting a beat with in_last=0 from channel g, the arbiter locks: grant=g regardless of other valids, until a beat with in_last=1 from g is accepted.
  - While locked and in_valid[g]=0, no channel is ready (bubble).
  - ptr updates only on the last beat.
  - Reset clears the lock.
- Disabled: the ports are absent and every beat is arbitrated independently.

Decomposition:
- Package rr_chan_mux_pkg:
  - function clog2_min1 (returns 1 for NCH<=2 edge cases).
  - default WIDTH/NCH localparams.
  - rr_state_t enum {UNLOCKED, LOCKED} used only under the macro.
- Sub-module rr_arbiter (NCH, SELW):
  - Holds ptr and the lock state.
  - Inputs: req, advance, last.
  - Outputs: grant index and grant_valid.
- rr_chan_mux instantiates rr_arbiter plus the data select and output register.

Test Plan:
1. Reset, then in_valid=4'b1111, out_ready=1 held: out_chan sequence 0,1,2,3,0 on successive cycles after the first edge; out_data matches the channel payloads (0x10,0x21,0x32,0x43).
2. Only channel 2 valid with ptr=3: grant wraps to 2; next ptr=3; in_ready=4'b0100.
3. out_valid=1 with out_ready=0 for 3 cycles: out_data=0xA5 and out_chan stay stable; in_ready=0; ptr is unchanged; on release the next beat loads in the same cycle as the drain.
4. Assert rst_n=0 mid-stream with out_valid=1: out_valid, out_data and out_chan go to 0 immediately, without a clock; after release, arbitration restarts at channel 0.
5. NCH=3, WIDTH=16, all valid: grants 0,1,2,0 and ptr never reaches 3.
6. RR_CHAN_MUX_LOCK_EN, channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout: out_chan=1,1,1 then 0; out_last=0,0,1; a bubble cycle with in_valid[1]=0 mid-packet yields in_ready=0 on all channels.
